hog_window_feeder: RTL

- Upstream feeder for the denoise/HOG top (the stage that drives its 5-row x 14-column, 560-bit pixel_in window).
- Accepts a raster pixel stream, 2 pixels per beat, with valid/ready.
- Buffers the rows in an 8-slot circular line buffer.
- Emits one 5x14 window per cycle in the order the HOG stage expects: row bands with a step of 3 rows; within a band, columns left to right with a step of 12.

---
 rtl/hog_window_feeder_if.sv | 30 +++
 rtl/hog_window_feeder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/hog_window_feeder_if.sv
// Stream-in / window-out bundle for hog_window_feeder.
//   s_valid, s_ready, s_data : raster pixel stream, 2 pixels per beat ([15:8] = even x)
//   win_valid, win_data      : one WIN_H x WIN_W window per cycle, no backpressure
//   win_row, win_col         : band index b and window index k of the current window
//   win_last, frame_done     : final window of the frame; pulse the cycle after it
// The slave modport is the feeder; the master modport is the pixel source and window sink.
interface hog_window_feeder_if #(
  parameter int unsigned WIN_W = 14,
  parameter int unsigned WIN_H = 5
);
  logic                       s_valid;
  logic                       s_ready;
  logic [15:0]                s_data;
  logic                       win_valid;
  logic [WIN_W*WIN_H*8-1:0]   win_data;
  logic [7:0]                 win_row;
  logic [5:0]                 win_col;
  logic                       win_last;
  logic                       frame_done;

  modport master (
    output s_valid, s_data,
    input  s_ready, win_valid, win_data, win_row, win_col, win_last, frame_done
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, win_valid, win_data, win_row, win_col, win_last, frame_done
  );
endinterface

// File: rtl/hog_window_feeder.sv
// Feeds the HOG/denoise stage: buffers a raster pixel stream in an 8-row circular line
// buffer and emits WIN_H x WIN_W windows band by band (band stride STEP_Y rows), left to
// right within a band (stride STEP_X pixels).
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - hog_window_feeder_if.slave (pixel stream in, windows out)
// win_data packs rows top to bottom, leftmost pixel of each row in its most significant byte.
module hog_window_feeder #(
  parameter int unsigned IMG_W  = 638,
  parameter int unsigned IMG_H  = 482,
  parameter int unsigned WIN_W  = 14,
  parameter int unsigned WIN_H  = 5,
  parameter int unsigned STEP_X = 12,
  parameter int unsigned STEP_Y = 3
) (
  input logic             clk,
  input logic             rst,
  hog_window_feeder_if.slave bus
);

  localparam int unsigned NWX      = (IMG_W - WIN_W) / STEP_X + 1;
  localparam int unsigned NB       = (IMG_H - WIN_H) / STEP_Y + 1;
  localparam int unsigned RowWords = IMG_W / 2;
  localparam int unsigned AddrW    = $clog2(RowWords);
  localparam int unsigned XW       = AddrW + 1;
  localparam int unsigned WinBits  = WIN_W * WIN_H * 8;

  typedef enum logic [1:0] {StFill, StEmit, StDone} state_e;

  state_e      state_q, state_d;
  logic [9:0]  wx_q, wx_d;
  logic [8:0]  wy_q, wy_d;
  logic        in_done_q, in_done_d;
  logic [7:0]  b_q, b_d;
  logic [5:0]  k_q, k_d;

  // One 16-bit word per beat; row y lives in slot y mod 8.
  logic [15:0] mem_q [8][RowWords];

  logic        s_ready;
  logic        accept;
  logic        fill_ok;
  logic [9:0]  band_y;
  logic [WinBits-1:0] win_data_c;

  assign band_y  = 10'(STEP_Y * b_q);
  // Stop ingest before it would reach a slot still holding rows of the pending band.
  assign s_ready = !in_done_q && ({1'b0, wy_q} < band_y + 10'd8);
  assign accept  = bus.s_valid && s_ready;
  // Last row of the band is complete once the writer has moved past it.
  assign fill_ok = in_done_q || ({1'b0, wy_q} > band_y + 10'(WIN_H - 1));

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wy_q[2:0]][wx_q[AddrW:1]] <= bus.s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFill;
      wx_q      <= '0;
      wy_q      <= '0;
      in_done_q <= 1'b0;
      b_q       <= '0;
      k_q       <= '0;
    end else begin
      state_q   <= state_d;
      wx_q      <= wx_d;
      wy_q      <= wy_d;
      in_done_q <= in_done_d;
      b_q       <= b_d;
      k_q       <= k_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wx_d      = wx_q;
    wy_d      = wy_q;
    in_done_d = in_done_q;
    b_d       = b_q;
    k_d       = k_q;

    if (accept) begin
      if (wx_q == 10'(IMG_W - 2)) begin
        wx_d = '0;
        wy_d = wy_q + 9'd1;
        if (wy_q == 9'(IMG_H - 1)) begin
          in_done_d = 1'b1;
        end
      end else begin
        wx_d = wx_q + 10'd2;
      end
    end

    unique case (state_q)
      StFill: begin
        if (fill_ok) begin
          state_d = StEmit;
          k_d     = '0;
        end
      end
      StEmit: begin
        if (k_q == 6'(NWX - 1)) begin
          k_d = '0;
          if (b_q == 8'(NB - 1)) begin
            state_d = StDone;
          end else begin
            b_d     = b_q + 8'd1;
            state_d = StFill;
          end
        end else begin
          k_d = k_q + 6'd1;
        end
      end
      StDone: begin
        // Ingest is already blocked by in_done, so clearing the pointers here is safe.
        state_d   = StFill;
        in_done_d = 1'b0;
        wx_d      = '0;
        wy_d      = '0;
        b_d       = '0;
        k_d       = '0;
      end
      default: state_d = StFill;
    endcase
  end

  // Window read straight from the line buffer, addressed by the registered (b, k).
  always_comb begin
    logic [XW-1:0] px_x;
    logic [2:0]    slot;
    logic [15:0]   word;
    win_data_c = '0;
    px_x       = '0;
    slot       = '0;
    word       = '0;
    if (state_q == StEmit) begin
      for (int r = 0; r < int'(WIN_H); r++) begin
        for (int c = 0; c < int'(WIN_W); c++) begin
          px_x = XW'(STEP_X * k_q + c);
          slot = band_y[2:0] + 3'(r);
          word = mem_q[slot][px_x[AddrW:1]];
          win_data_c[WinBits-1-8*(r*WIN_W+c) -: 8] = px_x[0] ? word[7:0] : word[15:8];
        end
      end
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.win_valid  = (state_q == StEmit);
  assign bus.win_data   = win_data_c;
  assign bus.win_row    = b_q;
  assign bus.win_col    = k_q;
  assign bus.win_last   = (state_q == StEmit) && (b_q == 8'(NB - 1)) && (k_q == 6'(NWX - 1));
  assign bus.frame_done = (state_q == StDone);

endmodule
